// File: rtl/phase_frame_spi_tx.sv
// rtl/phase_frame_spi_tx.sv - SPI mode-0 master streaming one phase frame to the ultrasonic receiver
//
// Purpose: takes NUM_CH bytes from an upstream valid/ready stream and shifts them out MSB first
// with spi_cs held low for the whole frame and a fixed idle gap between bytes. spi_sclk is
// derived from master_clock by dividing down to SCK_HALF cycles per half-period.
// Optional feature macro: FRAME_CHECKSUM_EN appends an XOR checksum of the data bytes as
// one extra byte at the end of the frame.
//
// Ports:
//   master_clock  in   system clock
//   rst           in   synchronous active-low reset
//   start         in   request a frame (acted on only while idle)
//   busy          out  high whenever a frame is in progress
//   s_data        in   upstream byte
//   s_valid       in   upstream byte valid
//   s_ready       out  upstream byte accepted when s_valid && s_ready
//   spi_sclk      out  SPI clock, idles low
//   spi_mosi      out  SPI data, MSB first
//   spi_cs        out  chip select, active low
//   frame_done    out  one-cycle pulse as spi_cs returns high after a complete frame
//   underflow     out  one-cycle pulse when a byte fetch begins with s_valid low
`timescale 1ns/1ps
module phase_frame_spi_tx #(
   parameter int NUM_CH   = 50,
   parameter int SCK_HALF = 25,
   parameter int BYTE_GAP = 100,
   parameter int CS_SETUP = 50,
   parameter int CS_HOLD  = 50
) (
   input  logic       master_clock,
   input  logic       rst,
   input  logic       start,
   output logic       busy,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   output logic       spi_sclk,
   output logic       spi_mosi,
   output logic       spi_cs,
   output logic       frame_done,
   output logic       underflow
);

   localparam int BW   = $clog2(NUM_CH + 1);
   localparam int HW   = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
   localparam int TMAX = (BYTE_GAP > CS_SETUP) ? ((BYTE_GAP > CS_HOLD) ? BYTE_GAP : CS_HOLD)
                                               : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_FETCH = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;
   localparam logic [2:0] S_HOLD  = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [7:0]    sh_q, sh_d;
   logic          start_q, start_d;
   logic          first_q, first_d;
   logic          cs_q, cs_d;
   logic          sclk_q, sclk_d;
   logic          mosi_q, mosi_d;
   logic          rdy_q, rdy_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          uf_q, uf_d;
`ifdef FRAME_CHECKSUM_EN
   logic [7:0]    csum_q, csum_d;
`endif

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      hcnt_d  = hcnt_q;
      bit_d   = bit_q;
      bcnt_d  = bcnt_q;
      sh_d    = sh_q;
      // start is only registered while idle, so a request made in the frame_done cycle
      // takes effect one cycle later and spi_cs stays high for at least two cycles.
      start_d = start && (state_q == S_IDLE);
      first_d = first_q;
      cs_d    = cs_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      rdy_d   = rdy_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      uf_d    = 1'b0;
`ifdef FRAME_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         S_IDLE: begin
            bcnt_d = '0;
`ifdef FRAME_CHECKSUM_EN
            csum_d = '0;
`endif
            if (start_q) begin
               state_d = S_SETUP;
               cs_d    = 1'b0;
               busy_d  = 1'b1;
               tmr_d   = '0;
            end
         end
         S_SETUP: begin
            if (tmr_q == TW'(CS_SETUP - 1)) begin
               state_d = S_FETCH;
               tmr_d   = '0;
               rdy_d   = 1'b1;
               first_d = 1'b1;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         S_FETCH: begin
            first_d = 1'b0;
            if (s_valid && rdy_q) begin
               sh_d    = s_data;
               mosi_d  = s_data[7];
               rdy_d   = 1'b0;
               bcnt_d  = bcnt_q + BW'(1);
               hcnt_d  = '0;
               bit_d   = '0;
               state_d = S_SHIFT;
`ifdef FRAME_CHECKSUM_EN
               csum_d  = csum_q ^ s_data;
`endif
            end else if (first_q) begin
               uf_d = 1'b1;
            end
         end
         S_SHIFT: begin
            if (hcnt_q == HW'(SCK_HALF - 1)) begin
               hcnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  // Falling edge: mosi moves to the next bit here so it is stable
                  // for the whole high half that follows.
                  sclk_d = 1'b0;
                  if (bit_q == 3'd7) begin
                     tmr_d = '0;
`ifdef FRAME_CHECKSUM_EN
                     // The checksum byte is the only one sent with bcnt already at
                     // NUM_CH on entry to GAP; after it, go straight to HOLD.
                     state_d = (bcnt_q < BW'(NUM_CH) || state_q == S_SHIFT && !sent_csum()) ?
                               S_GAP : S_HOLD;
`else
                     state_d = (bcnt_q < BW'(NUM_CH)) ? S_GAP : S_HOLD;
`endif
                  end else begin
                     bit_d  = bit_q + 3'd1;
                     sh_d   = {sh_q[6:0], 1'b0};
                     mosi_d = sh_q[6];
                  end
               end
            end else begin
               hcnt_d = hcnt_q + HW'(1);
            end
         end
         S_GAP: begin
            if (tmr_q == TW'(BYTE_GAP - 1)) begin
               tmr_d = '0;
`ifdef FRAME_CHECKSUM_EN
               if (bcnt_q == BW'(NUM_CH)) begin
                  sh_d    = csum_q;
                  mosi_d  = csum_q[7];
                  hcnt_d  = '0;
                  bit_d   = '0;
                  state_d = S_SHIFT;
               end else begin
                  state_d = S_FETCH;
                  rdy_d   = 1'b1;
                  first_d = 1'b1;
               end
`else
               state_d = S_FETCH;
               rdy_d   = 1'b1;
               first_d = 1'b1;
`endif
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         S_HOLD: begin
            if (tmr_q == TW'(CS_HOLD - 1)) begin
               state_d = S_IDLE;
               tmr_d   = '0;
               cs_d    = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               mosi_d  = 1'b0;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef FRAME_CHECKSUM_EN
   // The checksum byte is the one shifted after all NUM_CH data bytes were accepted; it is
   // recognised by the checksum-sent flag set when GAP loads it.
   logic sent_q, sent_d;

   function automatic logic sent_csum();
      return sent_q;
   endfunction

   always_comb begin
      sent_d = sent_q;
      if (state_q == S_IDLE) begin
         sent_d = 1'b0;
      end else if (state_q == S_GAP && tmr_q == TW'(BYTE_GAP - 1) && bcnt_q == BW'(NUM_CH)) begin
         sent_d = 1'b1;
      end
   end
`endif

   always_ff @(posedge master_clock) begin
      if (!rst) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         hcnt_q  <= '0;
         bit_q   <= '0;
         bcnt_q  <= '0;
         sh_q    <= '0;
         start_q <= 1'b0;
         first_q <= 1'b0;
         cs_q    <= 1'b1;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         uf_q    <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
         csum_q  <= '0;
         sent_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         hcnt_q  <= hcnt_d;
         bit_q   <= bit_d;
         bcnt_q  <= bcnt_d;
         sh_q    <= sh_d;
         start_q <= start_d;
         first_q <= first_d;
         cs_q    <= cs_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         uf_q    <= uf_d;
`ifdef FRAME_CHECKSUM_EN
         csum_q  <= csum_d;
         sent_q  <= sent_d;
`endif
      end
   end

   assign busy       = busy_q;
   assign s_ready    = rdy_q;
   assign spi_sclk   = sclk_q;
   assign spi_mosi   = mosi_q;
   assign spi_cs     = cs_q;
   assign frame_done = done_q;
   assign underflow  = uf_q;

endmodule

// File: tb/tb_phase_frame_spi_tx.sv
// tb/tb_phase_frame_spi_tx.sv - table-driven bench for phase_frame_spi_tx
`timescale 1ns/1ps
module tb_phase_frame_spi_tx;

   localparam int NUM_CH   = 3;
   localparam int SCK_HALF = 25;
   localparam int BYTE_GAP = 100;
   localparam int CS_SETUP = 50;
   localparam int CS_HOLD  = 50;
   localparam int BUDGET   = 6000;
`ifdef FRAME_CHECKSUM_EN
   localparam int NB = NUM_CH + 1;
`else
   localparam int NB = NUM_CH;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_valid = 1'b0;
   logic       busy, s_ready, spi_sclk, spi_mosi, spi_cs, frame_done, underflow;

   always #5 clk = ~clk;

   phase_frame_spi_tx #(
      .NUM_CH(NUM_CH), .SCK_HALF(SCK_HALF), .BYTE_GAP(BYTE_GAP),
      .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)
   ) dut (
      .master_clock(clk), .rst(rst), .start(start), .busy(busy),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
      .frame_done(frame_done), .underflow(underflow)
   );

   // slave model and protocol monitor, sampling between active edges
   int cyc = 0, rise_cnt = 0, fd_cnt = 0, fd_align = 0, uf_cnt = 0, acc_cnt = 0;
   int bad_mosi = 0, bad_high = 0, bad_low = 0, bad_gap = 0, bad_stall = 0;
   int hold_delta = 0, cs_high_len = 0, cs_rise_cyc = 0, last_edge_cyc = 0, last_fall_cyc = 0;
   int cap_bits = 0;
   logic [7:0] cap_sh = 8'h00;
   logic [7:0] cap_q[$];
   logic p_sclk = 1'b0, p_mosi = 1'b0, p_cs = 1'b1, fell_in_cs = 1'b0;

   always @(negedge clk) begin : mon
      logic [7:0] sh_n;
      int bits_n;
      sh_n = cap_sh;
      bits_n = (rst) ? cap_bits : 0;
      cyc <= cyc + 1;
      if (spi_sclk && !p_sclk) begin
         rise_cnt <= rise_cnt + 1;
         if (bits_n != 0 && (cyc - last_edge_cyc) != SCK_HALF) bad_low <= bad_low + 1;
         if (bits_n == 0 && fell_in_cs && (cyc - last_edge_cyc) < BYTE_GAP + SCK_HALF) bad_gap <= bad_gap + 1;
         if (spi_mosi != p_mosi) bad_mosi <= bad_mosi + 1;
         sh_n = {sh_n[6:0], spi_mosi};
         bits_n = bits_n + 1;
         if (bits_n == 8) begin
            cap_q.push_back(sh_n);
            bits_n = 0;
         end
         last_edge_cyc <= cyc;
      end
      if (!spi_sclk && p_sclk) begin
         if ((cyc - last_edge_cyc) != SCK_HALF) bad_high <= bad_high + 1;
         last_edge_cyc <= cyc;
         last_fall_cyc <= cyc;
      end
      if (spi_sclk && p_sclk && spi_mosi != p_mosi) bad_mosi <= bad_mosi + 1;
      if (spi_cs) fell_in_cs <= 1'b0;
      else if (!spi_sclk && p_sclk) fell_in_cs <= 1'b1;
      if (spi_cs && !p_cs) begin
         hold_delta <= cyc - last_fall_cyc;
         cs_rise_cyc <= cyc;
         if (frame_done) fd_align <= fd_align + 1;
      end
      if (!spi_cs && p_cs) cs_high_len <= cyc - cs_rise_cyc;
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (underflow) uf_cnt <= uf_cnt + 1;
      if (s_valid && s_ready && rst) acc_cnt <= acc_cnt + 1;
      if (s_ready && (spi_cs || spi_sclk)) bad_stall <= bad_stall + 1;
      cap_sh <= sh_n;
      cap_bits <= bits_n;
      p_sclk <= spi_sclk;
      p_mosi <= spi_mosi;
      p_cs <= spi_cs;
   end

   typedef struct {
      logic [7:0] b0, b1, b2;
      logic [7:0] csum;
      int stall_idx;
      int stall_len;
      bit chained;
      int exp_uf;
   } vec_t;

   vec_t vt[4];
   int errors = 0, checks = 0;
   int rb, fb, fab, ub, ab, mb, hb, lb, gb, sb, qb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic snap();
      rb = rise_cnt; fb = fd_cnt; fab = fd_align; ub = uf_cnt; ab = acc_cnt;
      mb = bad_mosi; hb = bad_high; lb = bad_low; gb = bad_gap; sb = bad_stall; qb = cap_q.size();
   endtask

   task automatic run_frame(input vec_t v, input bit do_start, input bit chain_next,
                            input int abort_rise, output bit done, output bit aborted);
      logic [7:0] bytes[3];
      int idx, stalled;
      bit acc;
      bytes[0] = v.b0; bytes[1] = v.b1; bytes[2] = v.b2;
      idx = 0; stalled = 0; acc = 1'b0; done = 1'b0; aborted = 1'b0;
      if (do_start) start = 1'b1;
      for (int c = 0; c < BUDGET; c++) begin
         if (acc) idx++;
         if (idx == v.stall_idx && stalled < v.stall_len) begin
            s_valid = 1'b0;
            if (s_ready) stalled++;
         end else if (idx < 3) begin
            s_valid = 1'b1;
            s_data = bytes[idx];
         end else begin
            s_valid = 1'b0;
         end
         acc = s_valid && s_ready && rst;
         if (c > 0 && frame_done) begin
            done = 1'b1;
            if (chain_next) start = 1'b1;
            break;
         end
         if (abort_rise > 0 && (rise_cnt - rb) >= abort_rise) begin
            aborted = 1'b1;
            break;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
   endtask

   task automatic check_frame(input string tag, input vec_t v, input bit done);
      int act;
      logic [7:0] exp;
      chk({tag, "_done_seen"}, done, 1);
      chk({tag, "_byte_count"}, cap_q.size() - qb, NB);
      for (int k = 0; k < NB; k++) begin
         case (k)
            0: exp = v.b0;
            1: exp = v.b1;
            2: exp = v.b2;
            default: exp = v.csum;
         endcase
         act = (qb + k < cap_q.size()) ? int'(cap_q[qb + k]) : 32'h100;
         chk($sformatf("%s_byte%0d", tag, k), act, {24'h0, exp});
      end
      chk({tag, "_rising_edges"}, rise_cnt - rb, 8 * NB);
      chk({tag, "_frame_done_pulses"}, fd_cnt - fb, 1);
      chk({tag, "_done_at_cs_rise"}, fd_align - fab, 1);
      chk({tag, "_underflow_pulses"}, uf_cnt - ub, v.exp_uf);
      chk({tag, "_accepts"}, acc_cnt - ab, NUM_CH);
      chk({tag, "_mosi_moved_high"}, bad_mosi - mb, 0);
      chk({tag, "_bad_high_half"}, bad_high - hb, 0);
      chk({tag, "_bad_low_half"}, bad_low - lb, 0);
      chk({tag, "_short_gap"}, bad_gap - gb, 0);
      chk({tag, "_stall_activity"}, bad_stall - sb, 0);
      chk({tag, "_cs_hold"}, hold_delta, CS_HOLD);
   endtask

   initial begin
      bit done, aborted;
      vt[0] = '{8'h44, 8'h55, 8'h3F, 8'h2E, -1, 0, 1'b0, 0};
      vt[1] = '{8'hA5, 8'h00, 8'hFF, 8'h5A, 1, 200, 1'b0, 1};
      vt[2] = '{8'h01, 8'h80, 8'h7E, 8'hFF, -1, 0, 1'b1, 0};
      vt[3] = '{8'h44, 8'h55, 8'h3F, 8'h2E, -1, 0, 1'b1, 0};

      // reset for three edges with a start pulse inside it
      rst = 1'b0;
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      chk("rst_cs", spi_cs, 1);
      chk("rst_sclk", spi_sclk, 0);
      chk("rst_mosi", spi_mosi, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", s_ready, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_underflow", underflow, 0);
      rst = 1'b1;
      repeat (20) begin @(posedge clk); #1; end
      chk("post_rst_busy", busy, 0);
      chk("post_rst_cs", spi_cs, 1);
      chk("post_rst_edges", rise_cnt, 0);

      for (int v = 0; v < 4; v++) begin
         snap();
         run_frame(vt[v], !vt[v].chained, (v < 3) ? vt[v + 1].chained : 1'b0, 0, done, aborted);
         @(negedge clk); #1;
         check_frame($sformatf("v%0d", v), vt[v], done);
         if (vt[v].chained) chk($sformatf("v%0d_cs_high_cycles", v), cs_high_len, 2);
      end

      // reset in the 4th bit of byte 2
      repeat (30) begin @(posedge clk); #1; end
      snap();
      run_frame(vt[0], 1'b1, 1'b0, 12, done, aborted);
      chk("abort_reached", aborted, 1);
      chk("abort_cs_low_before", spi_cs, 0);
      chk("abort_sclk_high_before", spi_sclk, 1);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_cs", spi_cs, 1);
      chk("abort_sclk", spi_sclk, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ready", s_ready, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (200) begin @(posedge clk); #1; end
      chk("abort_no_done", fd_cnt - fb, 0);
      chk("abort_bytes_whole", cap_q.size() - qb, 1);
      snap();
      run_frame(vt[1], 1'b1, 1'b0, 0, done, aborted);
      @(negedge clk); #1;
      check_frame("after_abort", vt[1], done);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
